// File: rtl/onchip_memory_dp.sv
// True-dual-port Avalon-MM on-chip RAM with byte enables, optional zero-clear
// after reset and a 1- or 2-stage readdatavalid pipeline.
module onchip_memory_dp #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned DEPTH          = 256,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned S2_WRITABLE    = 1,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,
  input  logic                    reset_req,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  output logic                    s1_waitrequest,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid,
  output logic                    s2_waitrequest
);

  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    w_ce;
  logic                    w_busy;
  logic                    w_clr_we;
  logic [IDX_W-1:0]        r_clr_addr;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

  logic [ADDR_WIDTH-1:0]   w_addr  [2];
  logic [NB-1:0]           w_be    [2];
  logic [DATA_WIDTH-1:0]   w_wdata [2];
  logic [1:0]              w_cs, w_rd, w_wr;

  logic [1:0]              w_in_rng, w_acc, w_rd_acc, w_we;
  logic [IDX_W-1:0]        w_idx   [2];
  logic [DATA_WIDTH-1:0]   w_rdata [2];
  logic [DATA_WIDTH-1:0]   w_mask  [2];
  logic [DATA_WIDTH-1:0]   w_wword [2];
  logic [DATA_WIDTH-1:0]   w_base1;
  logic                    w_same;

  logic [1:0]              r_v0;
  logic [DATA_WIDTH-1:0]   r_d0 [2];
  logic [1:0]              w_out_v;
  logic [DATA_WIDTH-1:0]   w_out_d [2];

  assign w_ce = clken & ~reset_req;

  assign w_addr[0]  = s1_address;
  assign w_addr[1]  = s2_address;
  assign w_be[0]    = s1_byteenable;
  assign w_be[1]    = s2_byteenable;
  assign w_wdata[0] = s1_writedata;
  assign w_wdata[1] = s2_writedata;
  assign w_cs       = {s2_chipselect, s1_chipselect};
  assign w_rd       = {s2_read, s1_read};
  assign w_wr       = {s2_write, s1_write};

  // State register; reset always restarts the clear sweep
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
    end else if (w_ce) begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clr_we    = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      ST_CLEAR: begin
        w_clr_we = w_ce & ~reset;
        if (r_clr_addr == IDX_W'(DEPTH - 1)) w_state_nxt = ST_READY;
      end
      ST_READY: w_busy = reset | ~w_ce;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_clr_addr <= '0;
    end else if (w_clr_we) begin
      r_clr_addr <= r_clr_addr + IDX_W'(1);
    end
  end

  // Per-port decode; read+write together counts as a write only
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_in_rng[p] = {1'b0, w_addr[p]} < DEPTH_L;
      w_idx[p]    = IDX_W'(w_addr[p]);
      w_acc[p]    = w_cs[p] & (w_rd[p] | w_wr[p]) & ~w_busy;
      w_rd_acc[p] = w_acc[p] & ~w_wr[p];
      w_we[p]     = w_acc[p] & w_wr[p] & w_in_rng[p];
      w_rdata[p]  = w_in_rng[p] ? r_mem[w_idx[p]] : '0;
      w_mask[p]   = '0;
      for (int unsigned b = 0; b < NB; b++) begin
        w_mask[p][b*8 +: 8] = {8{w_be[p][b]}};
      end
    end
    if (S2_WRITABLE == 0) w_we[1] = 1'b0;
  end

  // Same-address dual write folds s2 lanes under s1 lanes into one word
  always_comb begin
    w_same     = w_we[0] & w_we[1] & (w_idx[0] == w_idx[1]);
    w_base1    = r_mem[w_idx[0]];
    if (w_same) w_base1 = (w_base1 & ~w_mask[1]) | (w_wdata[1] & w_mask[1]);
    w_wword[0] = (w_base1 & ~w_mask[0]) | (w_wdata[0] & w_mask[0]);
    w_wword[1] = (r_mem[w_idx[1]] & ~w_mask[1]) | (w_wdata[1] & w_mask[1]);
  end

  always_ff @(posedge clk) begin
    if (w_clr_we)          r_mem[r_clr_addr] <= '0;
    if (w_we[1] & ~w_same) r_mem[w_idx[1]]   <= w_wword[1];
    if (w_we[0])           r_mem[w_idx[0]]   <= w_wword[0];
  end

  // First read stage: data register only loads on an accepted read
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v0    <= '0;
      r_d0[0] <= '0;
      r_d0[1] <= '0;
    end else if (w_ce) begin
      r_v0 <= w_rd_acc;
      if (w_rd_acc[0]) r_d0[0] <= w_rdata[0];
      if (w_rd_acc[1]) r_d0[1] <= w_rdata[1];
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_rl2
      logic [1:0]            r_v1;
      logic [DATA_WIDTH-1:0] r_d1 [2];

      always_ff @(posedge clk) begin
        if (reset) begin
          r_v1    <= '0;
          r_d1[0] <= '0;
          r_d1[1] <= '0;
        end else if (w_ce) begin
          r_v1 <= r_v0;
          if (r_v0[0]) r_d1[0] <= r_d0[0];
          if (r_v0[1]) r_d1[1] <= r_d0[1];
        end
      end

      assign w_out_v    = r_v1;
      assign w_out_d[0] = r_d1[0];
      assign w_out_d[1] = r_d1[1];
    end else begin : g_rl1
      assign w_out_v    = r_v0;
      assign w_out_d[0] = r_d0[0];
      assign w_out_d[1] = r_d0[1];
    end
  endgenerate

  // A pending pulse is masked while frozen and emitted on the next ce cycle
  assign s1_readdata      = w_out_d[0];
  assign s2_readdata      = w_out_d[1];
  assign s1_readdatavalid = w_out_v[0] & w_ce & ~reset;
  assign s2_readdatavalid = w_out_v[1] & w_ce & ~reset;
  assign s1_waitrequest   = w_busy;
  assign s2_waitrequest   = w_busy;

endmodule

// File: tb/tb_onchip_memory_dp.sv
// Bench for onchip_memory_dp: two instances (default build, and a
// 200-word / latency-2 / read-only-s2 / no-clear build) against a word-level model.
module tb_onchip_memory_dp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [2];
  logic        clken [2];
  logic        rreq  [2];
  logic [7:0]  addr  [2][2];
  logic        cs    [2][2];
  logic        rd    [2][2];
  logic        wr    [2][2];
  logic [3:0]  be    [2][2];
  logic [31:0] wd    [2][2];
  logic [31:0] rdata [2][2];
  logic        rdv   [2][2];
  logic        wreq  [2][2];

  int n_tests = 0;
  int n_fail  = 0;

  onchip_memory_dp u_a (
    .clk(clk), .reset(rst[0]), .clken(clken[0]), .reset_req(rreq[0]),
    .s1_address(addr[0][0]), .s1_chipselect(cs[0][0]), .s1_read(rd[0][0]), .s1_write(wr[0][0]),
    .s1_byteenable(be[0][0]), .s1_writedata(wd[0][0]), .s1_readdata(rdata[0][0]),
    .s1_readdatavalid(rdv[0][0]), .s1_waitrequest(wreq[0][0]),
    .s2_address(addr[0][1]), .s2_chipselect(cs[0][1]), .s2_read(rd[0][1]), .s2_write(wr[0][1]),
    .s2_byteenable(be[0][1]), .s2_writedata(wd[0][1]), .s2_readdata(rdata[0][1]),
    .s2_readdatavalid(rdv[0][1]), .s2_waitrequest(wreq[0][1])
  );

  onchip_memory_dp #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(200), .READ_LATENCY(2),
    .S2_WRITABLE(0), .CLEAR_ON_RESET(0)
  ) u_b (
    .clk(clk), .reset(rst[1]), .clken(clken[1]), .reset_req(rreq[1]),
    .s1_address(addr[1][0]), .s1_chipselect(cs[1][0]), .s1_read(rd[1][0]), .s1_write(wr[1][0]),
    .s1_byteenable(be[1][0]), .s1_writedata(wd[1][0]), .s1_readdata(rdata[1][0]),
    .s1_readdatavalid(rdv[1][0]), .s1_waitrequest(wreq[1][0]),
    .s2_address(addr[1][1]), .s2_chipselect(cs[1][1]), .s2_read(rd[1][1]), .s2_write(wr[1][1]),
    .s2_byteenable(be[1][1]), .s2_writedata(wd[1][1]), .s2_readdata(rdata[1][1]),
    .s2_readdatavalid(rdv[1][1]), .s2_waitrequest(wreq[1][1])
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic int dep(int k);  return (k == 0) ? 256 : 200; endfunction
  function automatic int rlat(int k); return (k == 0) ? 1 : 2;     endfunction
  function automatic bit s2w(int k);  return (k == 0);             endfunction
  function automatic bit clr(int k);  return (k == 0);             endfunction

  // Model: word array, remaining clear cycles, ce-cycle index, FIFO of expected returns
  logic [31:0] mem      [2][256];
  int          clr_left [2];
  int          ce_idx   [2];
  logic [31:0] last     [2][2];
  logic [31:0] qd       [2][2][8];
  int          qdue     [2][2][8];
  int          hd       [2][2];
  int          tl       [2][2];

  always @(negedge clk) begin
    logic       ce, bsy, ev;
    logic [1:0] acc;
    bit         w1, w2;
    int         a0, a1;
    for (int k = 0; k < 2; k++) begin
      ce  = clken[k] & ~rreq[k];
      bsy = rst[k] | ~ce | (clr_left[k] > 0);
      for (int p = 0; p < 2; p++)
        chk($sformatf("waitrequest[%0d][%0d]", k, p), 32'(wreq[k][p]), 32'(bsy));
      if (rst[k]) begin
        for (int p = 0; p < 2; p++) begin
          chk($sformatf("rdv_in_reset[%0d][%0d]", k, p), 32'(rdv[k][p]), 32'd0);
          hd[k][p]   = tl[k][p];
          last[k][p] = '0;
        end
        clr_left[k] = clr(k) ? dep(k) : 0;
        if (clr(k)) for (int a = 0; a < 256; a++) mem[k][a] = '0;
      end else begin
        for (int p = 0; p < 2; p++) begin
          ev = ce && (hd[k][p] != tl[k][p]) && (qdue[k][p][hd[k][p] % 8] == ce_idx[k]);
          chk($sformatf("rdv[%0d][%0d] ce#%0d", k, p, ce_idx[k]), 32'(rdv[k][p]), 32'(ev));
          if (ev) begin
            last[k][p] = qd[k][p][hd[k][p] % 8];
            hd[k][p]++;
          end
          if (ce) chk($sformatf("readdata[%0d][%0d] ce#%0d", k, p, ce_idx[k]), rdata[k][p], last[k][p]);
        end
        if (ce) begin
          if (clr_left[k] > 0) begin
            clr_left[k]--;
          end else begin
            for (int p = 0; p < 2; p++) begin
              acc[p] = cs[k][p] & (rd[k][p] | wr[k][p]);
              if (acc[p] && !wr[k][p]) begin
                qd[k][p][tl[k][p] % 8]   = (int'(addr[k][p]) < dep(k)) ? mem[k][addr[k][p]] : 32'h0;
                qdue[k][p][tl[k][p] % 8] = ce_idx[k] + rlat(k);
                tl[k][p]++;
              end
            end
            a0 = int'(addr[k][0]);
            a1 = int'(addr[k][1]);
            w1 = acc[0] && wr[k][0] && (a0 < dep(k));
            w2 = acc[1] && wr[k][1] && s2w(k) && (a1 < dep(k));
            for (int b = 0; b < 4; b++) begin
              if (w1 && be[k][0][b]) mem[k][a0][b*8 +: 8] = wd[k][0][b*8 +: 8];
              if (w2 && be[k][1][b] && !(w1 && a0 == a1 && be[k][0][b]))
                mem[k][a1][b*8 +: 8] = wd[k][1][b*8 +: 8];
            end
          end
          ce_idx[k]++;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 2; p++) begin
        cs[k][p] = 1'b0; rd[k][p] = 1'b0; wr[k][p] = 1'b0;
      end
  endtask

  task automatic wr1(int k, int p, logic [7:0] a, logic [31:0] d, logic [3:0] b);
    cs[k][p] = 1'b1; wr[k][p] = 1'b1; rd[k][p] = 1'b0;
    addr[k][p] = a; wd[k][p] = d; be[k][p] = b;
  endtask

  task automatic rd1(int k, int p, logic [7:0] a);
    cs[k][p] = 1'b1; rd[k][p] = 1'b1; wr[k][p] = 1'b0; addr[k][p] = a;
  endtask

  // Waits a bounded number of cycles for one pulse; lat 0 means none arrived
  task automatic get_rd(int k, int p, output logic [31:0] d, output int lat);
    d = '0; lat = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (rdv[k][p]) begin d = rdata[k][p]; lat = i; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic read_chk(int k, int p, logic [7:0] a, logic [31:0] exp, string nm);
    logic [31:0] d;
    int          lat;
    idle(); rd1(k, p, a); cyc(); idle();
    get_rd(k, p, d, lat);
    chk({nm, "_data"}, d, exp);
    chk({nm, "_latency"}, 32'(lat), 32'(rlat(k)));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n_busy, np;
    int          pc  [4];
    logic [31:0] got [4];
    logic [31:0] initb [200];

    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; clken[k] = 1'b1; rreq[k] = 1'b0;
      for (int p = 0; p < 2; p++) begin
        cs[k][p] = 0; rd[k][p] = 0; wr[k][p] = 0;
        addr[k][p] = '0; be[k][p] = '0; wd[k][p] = '0;
      end
    end
    repeat (3) cyc();
    rst[0] = 1'b0; rst[1] = 1'b0;

    // Clear sweep length, then a cleared word comes back as zero
    n_busy = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (wreq[0][0]) n_busy++; else break;
    end
    @(posedge clk); #1;
    chk("t1_clear_cycles", 32'(n_busy), 32'd256);
    read_chk(0, 0, 8'h80, 32'h0, "t1_read_0x80");

    // Byte lanes
    idle(); wr1(0, 0, 8'd5, 32'h11223344, 4'hF); cyc();
    idle(); wr1(0, 0, 8'd5, 32'hDEADBEEF, 4'b0101); cyc();
    read_chk(0, 1, 8'd5, 32'h11AD33EF, "t2_byte_lanes");

    // Read-during-write from the other port sees old data
    np = 0;
    for (int c = 0; c < 5; c++) begin
      idle();
      if (c == 0) begin wr1(0, 0, 8'd9, 32'hAAAAAAAA, 4'hF); rd1(0, 1, 8'd9); end
      if (c == 1) rd1(0, 1, 8'd9);
      @(negedge clk);
      if (rdv[0][1] && np < 4) begin got[np] = rdata[0][1]; pc[np] = c; np++; end
      @(posedge clk); #1;
    end
    chk("t3_pulses", 32'(np), 32'd2);
    chk("t3_old_data", got[0], 32'h0);
    chk("t3_new_data", got[1], 32'hAAAAAAAA);
    chk("t3_pulse0_cycle", 32'(pc[0]), 32'd1);
    chk("t3_pulse1_cycle", 32'(pc[1]), 32'd2);

    // Dual write to one address
    idle(); wr1(0, 0, 8'd3, 32'h11111111, 4'b0011); wr1(0, 1, 8'd3, 32'h22222222, 4'b1110); cyc();
    read_chk(0, 0, 8'd3, 32'h22221111, "t4_dual_write");

    // Load the no-clear instance with known contents
    for (int a = 0; a < 200; a++) begin
      initb[a] = $urandom;
      idle(); wr1(1, 0, 8'(a), initb[a], 4'hF); cyc();
    end
    idle();

    // Latency-2 burst, without and with a 3-cycle freeze
    for (int run = 0; run < 2; run++) begin
      np = 0;
      for (int c = 0; c < 12; c++) begin
        idle();
        clken[1] = !(run == 1 && c >= 4 && c <= 6);
        if (c < 4) rd1(1, 0, 8'(c));
        @(negedge clk);
        if (rdv[1][0] && np < 4) begin got[np] = rdata[1][0]; pc[np] = c; np++; end
        @(posedge clk); #1;
      end
      clken[1] = 1'b1;
      chk($sformatf("t5_run%0d_pulses", run), 32'(np), 32'd4);
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("t5_run%0d_cycle%0d", run, i), 32'(pc[i]), 32'(2 + i + ((run == 1 && i >= 2) ? 3 : 0)));
        chk($sformatf("t5_run%0d_data%0d", run, i), got[i], initb[i]);
      end
    end

    // Reset discards in-flight reads; contents survive
    np = 0;
    for (int c = 0; c < 10; c++) begin
      idle();
      rst[1] = (c == 2 || c == 3);
      if (c == 0) rd1(1, 0, 8'd10);
      if (c == 1) rd1(1, 0, 8'd11);
      @(negedge clk);
      if (rdv[1][0]) np++;
      @(posedge clk); #1;
    end
    rst[1] = 1'b0;
    chk("t6_no_pulse_after_reset", 32'(np), 32'd0);
    read_chk(1, 0, 8'd12, initb[12], "t6_retained");

    // Read-only s2 still accepts writes
    idle(); wr1(1, 1, 8'd7, ~initb[7], 4'hF);
    @(negedge clk);
    chk("t6_s2_write_accepted", 32'(wreq[1][1]), 32'd0);
    @(posedge clk); #1;
    read_chk(1, 1, 8'd7, initb[7], "t6_s2_readonly");

    // Address boundary on the 200-word instance
    idle(); wr1(1, 0, 8'd199, 32'hCAFEF00D, 4'hF); cyc();
    idle(); wr1(1, 0, 8'd210, 32'h12345678, 4'hF); cyc();
    read_chk(1, 1, 8'd199, 32'hCAFEF00D, "oob_last_word");
    read_chk(1, 0, 8'd210, 32'h0, "oob_dropped_write");
    read_chk(1, 1, 8'd255, 32'h0, "oob_read_top");

    // Randomised traffic on both instances
    for (int i = 0; i < 4000; i++) begin
      for (int k = 0; k < 2; k++) begin
        rst[k]   = ($urandom_range(0, 1499) == 0);
        clken[k] = ($urandom_range(0, 9) != 0);
        rreq[k]  = ($urandom_range(0, 19) == 0);
        for (int p = 0; p < 2; p++) begin
          cs[k][p]   = ($urandom_range(0, 3) != 0);
          rd[k][p]   = 1'($urandom_range(0, 1));
          wr[k][p]   = ($urandom_range(0, 2) == 0);
          addr[k][p] = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255));
          be[k][p]   = 4'($urandom);
          wd[k][p]   = $urandom;
        end
      end
      cyc();
    end
    idle();
    for (int k = 0; k < 2; k++) begin rst[k] = 1'b0; clken[k] = 1'b1; rreq[k] = 1'b0; end
    repeat (8) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
